// File: rtl/multu_hilo_unit_pkg.sv
// rtl/multu_hilo_unit_pkg.sv - shared funct codes, state enum and width default for the HI/LO unit
package multu_hilo_unit_pkg;

    localparam int WIDTH_DEF = 32;

    // R-type funct codes, shared with the EX-stage result mux
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] MTHI  = 6'b010001;
    localparam logic [5:0] MTLO  = 6'b010011;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MFLO  = 6'b010010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multu_hilo_unit_if.sv
// rtl/multu_hilo_unit_if.sv - command and HI/LO result bundle between control unit and HI/LO unit
import multu_hilo_unit_pkg::*;

interface multu_hilo_unit_if #(
    parameter int WIDTH = WIDTH_DEF
);
    logic             en;
    logic [5:0]       funct;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             busy;
    logic             done;

    modport master (
        output en, funct, src_a, src_b,
        input  hi_out, lo_out, busy, done
    );

    modport slave (
        input  en, funct, src_a, src_b,
        output hi_out, lo_out, busy, done
    );
endinterface

// File: rtl/multu_hilo_unit_shift_add_step.sv
// rtl/multu_hilo_unit_shift_add_step.sv - one combinational shift-add multiply iteration
import multu_hilo_unit_pkg::*;

module multu_hilo_unit_shift_add_step #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [2*WIDTH-1:0] product,
    input  logic [WIDTH-1:0]   multiplicand,
    output logic [2*WIDTH-1:0] next_product
);
    logic [WIDTH:0] sum;

    // Add the multiplicand into the upper half when the current multiplier bit is set, keep the carry, shift right
    always_comb begin
        sum          = {1'b0, product[2*WIDTH-1:WIDTH]} + (product[0] ? {1'b0, multiplicand} : '0);
        next_product = {sum, product[WIDTH-1:1]};
    end
endmodule

// File: rtl/multu_hilo_unit.sv
// rtl/multu_hilo_unit.sv - sequential MULTU plus MTHI/MTLO producer for the HI/LO registers
import multu_hilo_unit_pkg::*;

module multu_hilo_unit #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    multu_hilo_unit_if.slave    bus
);
    state_t             state;
    logic [CNT_W-1:0]   counter;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] next_product;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;

    multu_hilo_unit_shift_add_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .product      (product),
        .multiplicand (multiplicand),
        .next_product (next_product)
    );

    // Command decode, iteration control and HI/LO commit; busy/done are registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            counter      <= '0;
            product      <= '0;
            multiplicand <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        case (bus.funct)
                            MULTU: begin
                                multiplicand <= bus.src_a;
                                product      <= {{WIDTH{1'b0}}, bus.src_b};
                                counter      <= '0;
                                busy_q       <= 1'b1;
                                state        <= MUL;
                            end
                            MTHI:    hi_q <= bus.src_a;
                            MTLO:    lo_q <= bus.src_a;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    product <= next_product;
                    counter <= counter + 1'b1;
                    if (counter == CNT_W'(WIDTH - 1)) begin
                        hi_q   <= next_product[2*WIDTH-1:WIDTH];
                        lo_q   <= next_product[WIDTH-1:0];
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_multu_hilo_unit.sv
// tb/tb_multu_hilo_unit.sv - self-checking bench for multu_hilo_unit
import multu_hilo_unit_pkg::*;

module tb_multu_hilo_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    multu_hilo_unit_if #(.WIDTH(32)) bus ();

    multu_hilo_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_multu(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] ehi, input logic [31:0] elo,
                             input logic [31:0] phi, input logic [31:0] plo, input string tag);
        int n;
        bit held;
        n = 0;
        held = 1'b1;
        bus.en = 1'b1; bus.funct = MULTU; bus.src_a = a; bus.src_b = b;
        tick();
        bus.en = 1'b0;
        while (bus.busy && n < 100) begin
            if (bus.hi_out !== phi || bus.lo_out !== plo) held = 1'b0;
            tick();
            n++;
        end
        chk({tag, "_busy_cycles"}, 64'(n), 64'd32);
        chk({tag, "_hilo_held"}, 64'(held), 64'd1);
        chk({tag, "_done"}, 64'(bus.done), 64'd1);
        chk({tag, "_hi"}, 64'(bus.hi_out), 64'(ehi));
        chk({tag, "_lo"}, 64'(bus.lo_out), 64'(elo));
        tick();
        chk({tag, "_done_cleared"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        logic [31:0] mh, ml, a, b;
        logic [63:0] prod;
        logic [5:0]  f;
        int          sel;
        bit          saw_done;

        vecs[0] = '{32'd7,         32'd6,         32'h0000_0000, 32'h0000_002A};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        vecs[3] = '{32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE};
        vecs[4] = '{32'd0,         32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
        vecs[5] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[6] = '{32'd1,         32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[7] = '{32'd3,         32'd5,         32'h0000_0000, 32'h0000_000F};

        bus.en = 1'b0; bus.funct = 6'd0; bus.src_a = '0; bus.src_b = '0;

        // reset state
        #12;
        chk("rst_hi", 64'(bus.hi_out), 64'd0);
        chk("rst_lo", 64'(bus.lo_out), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        rst_n = 1'b1;
        tick();

        // table-driven multiplies
        mh = 32'd0; ml = 32'd0;
        for (int i = 0; i < 8; i++) begin
            run_multu(vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, mh, ml, $sformatf("vec%0d", i));
            mh = vecs[i].hi; ml = vecs[i].lo;
        end

        // MTHI then MTLO on consecutive cycles
        bus.en = 1'b1; bus.funct = MTHI; bus.src_a = 32'hDEAD_BEEF;
        tick();
        chk("mthi_hi", 64'(bus.hi_out), 64'hDEAD_BEEF);
        chk("mthi_lo_kept", 64'(bus.lo_out), 64'(ml));
        bus.funct = MTLO; bus.src_a = 32'hCAFE_F00D;
        tick();
        bus.en = 1'b0;
        chk("mtlo_lo", 64'(bus.lo_out), 64'hCAFE_F00D);
        chk("mtlo_hi_kept", 64'(bus.hi_out), 64'hDEAD_BEEF);
        chk("mtx_busy", 64'(bus.busy), 64'd0);
        chk("mtx_done", 64'(bus.done), 64'd0);

        // commands while busy are ignored
        bus.en = 1'b1; bus.funct = MULTU; bus.src_a = 32'd3; bus.src_b = 32'd5;
        tick();
        bus.en = 1'b0;
        tick(); tick();
        bus.en = 1'b1; bus.funct = MTHI; bus.src_a = 32'h1234;
        tick();
        chk("busy_mthi_ignored", 64'(bus.hi_out), 64'hDEAD_BEEF);
        bus.funct = MULTU; bus.src_a = 32'd9; bus.src_b = 32'd9;
        tick();
        bus.en = 1'b0;
        for (int i = 0; i < 60 && !bus.done; i++) tick();
        chk("busy_done_seen", 64'(bus.done), 64'd1);
        chk("busy_final_hi", 64'(bus.hi_out), 64'd0);
        chk("busy_final_lo", 64'(bus.lo_out), 64'd15);
        tick();
        chk("busy_no_restart", 64'(bus.busy), 64'd0);

        // back-to-back: strobe in DONE is ignored, next cycle is accepted
        bus.en = 1'b1; bus.funct = MULTU; bus.src_a = 32'd2; bus.src_b = 32'd3;
        tick();
        bus.en = 1'b0;
        for (int i = 0; i < 60 && !bus.done; i++) tick();
        chk("b2b_first_done", 64'(bus.done), 64'd1);
        chk("b2b_first_lo", 64'(bus.lo_out), 64'd6);
        bus.en = 1'b1; bus.funct = MULTU; bus.src_a = 32'd4; bus.src_b = 32'd4;
        tick();
        chk("b2b_done_strobe_ignored", 64'(bus.busy), 64'd0);
        tick();
        bus.en = 1'b0;
        chk("b2b_second_started", 64'(bus.busy), 64'd1);
        for (int i = 0; i < 60 && !bus.done; i++) tick();
        chk("b2b_second_done", 64'(bus.done), 64'd1);
        chk("b2b_hi", 64'(bus.hi_out), 64'd0);
        chk("b2b_lo", 64'(bus.lo_out), 64'd16);
        tick();

        // randomized commands against an arithmetic model of HI/LO
        mh = 32'd0; ml = 32'd16;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 5);
            a = $urandom; b = $urandom;
            if (sel == 0) begin
                if ($urandom_range(0, 1) == 1) a = a & 32'h0000_FFFF;
                prod = 64'(a) * 64'(b);
                run_multu(a, b, prod[63:32], prod[31:0], mh, ml, $sformatf("rnd%0d_multu", i));
                mh = prod[63:32]; ml = prod[31:0];
            end else begin
                case (sel)
                    1: f = MTHI;
                    2: f = MTLO;
                    3: f = MFHI;
                    4: begin
                        f = 6'($urandom);
                        while (f == MULTU || f == MTHI || f == MTLO) f = 6'($urandom);
                    end
                    default: f = MULTU;
                endcase
                bus.en = (sel != 5); bus.funct = f; bus.src_a = a; bus.src_b = b;
                tick();
                bus.en = 1'b0;
                if (sel == 1) mh = a;
                if (sel == 2) ml = a;
                chk($sformatf("rnd%0d_hi", i), 64'(bus.hi_out), 64'(mh));
                chk($sformatf("rnd%0d_lo", i), 64'(bus.lo_out), 64'(ml));
                chk($sformatf("rnd%0d_busy", i), 64'(bus.busy), 64'd0);
            end
        end

        // make HI/LO nonzero so the asynchronous clear is visible
        bus.en = 1'b1; bus.funct = MTHI; bus.src_a = 32'h5555_AAAA;
        tick();
        bus.funct = MTLO; bus.src_a = 32'hAAAA_5555;
        tick();

        // reset in the middle of a multiply
        bus.funct = MULTU; bus.src_a = 32'd7; bus.src_b = 32'd6;
        tick();
        bus.en = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("abort_busy_before", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_hi", 64'(bus.hi_out), 64'd0);
        chk("abort_lo", 64'(bus.lo_out), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        #1;
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        chk("abort_no_done", 64'(saw_done), 64'd0);
        chk("abort_hi_after", 64'(bus.hi_out), 64'd0);
        chk("abort_lo_after", 64'(bus.lo_out), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
